// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, programmable almost-full/almost-empty
// thresholds, sticky overflow/underflow flags and a registered read-valid strobe.
module sync_fifo_flags #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int AF_LEVEL   = 14,
   parameter int AE_LEVEL   = 2,
   localparam int AW        = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [AW:0]           count,
   output logic                  overflow,
   output logic                  underflow,
   input  logic                  clr_err
);

   localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];
   localparam logic [AW:0] AF_CNT    = AF_LEVEL[AW:0];
   localparam logic [AW:0] AE_CNT    = AE_LEVEL[AW:0];
   localparam logic [AW:0] ONE       = {{AW{1'b0}}, 1'b1};

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW:0]           wr_ptr;
   logic [AW:0]           rd_ptr;
   logic [AW:0]           count_r;
   logic                  wr_ok;
   logic                  rd_ok;

   // Flags and acceptance are decoded from the registered count only,
   // so every output changes strictly on clock edges.
   assign full         = (count_r == DEPTH_CNT);
   assign empty        = (count_r == '0);
   assign almost_full  = (count_r >= AF_CNT);
   assign almost_empty = (count_r <= AE_CNT);
   assign count        = count_r;

   assign wr_ok = wr_en & ~full;
   assign rd_ok = rd_en & ~empty;

   always_ff @(posedge clk) begin
      if (!rst && wr_ok) begin
         mem[wr_ptr[AW-1:0]] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count_r  <= '0;
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= rd_ok;
         if (wr_ok) begin
            wr_ptr <= wr_ptr + ONE;
         end
         if (rd_ok) begin
            rd_ptr  <= rd_ptr + ONE;
            rd_data <= mem[rd_ptr[AW-1:0]];
         end
         case ({wr_ok, rd_ok})
            2'b10:   count_r <= count_r + ONE;
            2'b01:   count_r <= count_r - ONE;
            default: count_r <= count_r;
         endcase
      end
   end

   // A new error in the same cycle as clr_err wins because its assignment comes last.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (clr_err) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
         end
         if (wr_en && full) begin
            overflow <= 1'b1;
         end
         if (rd_en && empty) begin
            underflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench for sync_fifo_flags: a vector table for basic cycles plus
// hand-written sequences for fill/drain, wrap, simultaneous access and reset.
module tb_sync_fifo_flags;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       wr_en = 1'b0;
   logic [7:0] wr_data = '0;
   logic       rd_en = 1'b0;
   logic       clr_err = 1'b0;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       full;
   logic       empty;
   logic       almost_full;
   logic       almost_empty;
   logic [4:0] count;
   logic       overflow;
   logic       underflow;

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q[$];
   logic [7:0] exp_word;

   sync_fifo_flags #(
      .DATA_WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2)
   ) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
      .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
      .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
      .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       wr;
      logic [7:0] wd;
      logic       rd;
      logic       clr;
      int         cnt;
      logic       ovf;
      logic       unf;
      logic       rv;
      logic [7:0] rdata;
   } vec_t;

   vec_t vecs[13];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Inputs change 1 time unit after an edge; outputs are sampled 1 unit after the next edge.
   task automatic cycle(input logic r, input logic w, input logic [7:0] d,
                        input logic rd, input logic c);
      rst = r; wr_en = w; wr_data = d; rd_en = rd; clr_err = c;
      @(posedge clk);
      #1;
      rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
   endtask

   task automatic check_flags(input string tag, input int cnt);
      check({tag, " count"}, int'(count), cnt);
      check({tag, " empty"}, int'(empty), int'(cnt == 0));
      check({tag, " full"}, int'(full), int'(cnt == 16));
      check({tag, " almost_full"}, int'(almost_full), int'(cnt >= 14));
      check({tag, " almost_empty"}, int'(almost_empty), int'(cnt <= 2));
   endtask

   initial begin
      //            rst   wr    wd     rd    clr   cnt ovf   unf   rv    rdata
      vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 8'h00};
      vecs[1]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 8'h00};
      vecs[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 8'h00};
      vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 8'h00};
      vecs[4]  = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 8'h00};
      vecs[5]  = '{1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 8'h00};
      vecs[6]  = '{1'b0, 1'b1, 8'h33, 1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b1, 8'h11};
      vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 8'h11};
      vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b1, 8'h22};
      vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1, 8'h33};
      vecs[10] = '{1'b0, 1'b1, 8'h44, 1'b1, 1'b0, 1, 1'b0, 1'b1, 1'b0, 8'h33};
      vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b1, 8'h44};
      vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 8'h44};

      for (int i = 0; i < 13; i++) begin
         cycle(vecs[i].rst, vecs[i].wr, vecs[i].wd, vecs[i].rd, vecs[i].clr);
         check_flags($sformatf("vec%0d", i), vecs[i].cnt);
         check($sformatf("vec%0d overflow", i), int'(overflow), int'(vecs[i].ovf));
         check($sformatf("vec%0d underflow", i), int'(underflow), int'(vecs[i].unf));
         check($sformatf("vec%0d rd_valid", i), int'(rd_valid), int'(vecs[i].rv));
         check($sformatf("vec%0d rd_data", i), int'(rd_data), int'(vecs[i].rdata));
      end

      // Fill to full with 0x00..0x0F, then one rejected write of 0xAA.
      for (int i = 0; i < 16; i++) begin
         cycle(1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
         check_flags($sformatf("fill%0d", i), i + 1);
      end
      cycle(1'b0, 1'b1, 8'hAA, 1'b0, 1'b0);
      check_flags("overfill", 16);
      check("overfill overflow", int'(overflow), 1);

      // Drain; 0xAA must not appear.
      for (int i = 0; i < 16; i++) begin
         cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
         check($sformatf("drain%0d rd_valid", i), int'(rd_valid), 1);
         check($sformatf("drain%0d rd_data", i), int'(rd_data), i);
         check_flags($sformatf("drain%0d", i), 15 - i);
      end
      cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      check("overread underflow", int'(underflow), 1);
      check("overread rd_valid", int'(rd_valid), 0);
      check("overread rd_data held", int'(rd_data), 8'h0F);
      check_flags("overread", 0);
      cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      check("clear overflow", int'(overflow), 0);
      check("clear underflow", int'(underflow), 0);

      // Streaming at constant occupancy 5 across pointer wraps.
      for (int i = 0; i < 5; i++) begin
         cycle(1'b0, 1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
         exp_q.push_back(8'(8'h80 + i));
      end
      check_flags("stream prefill", 5);
      for (int i = 0; i < 40; i++) begin
         cycle(1'b0, 1'b1, 8'(8'hC0 + i), 1'b1, 1'b0);
         exp_q.push_back(8'(8'hC0 + i));
         exp_word = exp_q.pop_front();
         check($sformatf("stream%0d rd_valid", i), int'(rd_valid), 1);
         check($sformatf("stream%0d rd_data", i), int'(rd_data), int'(exp_word));
         check($sformatf("stream%0d count", i), int'(count), 5);
      end
      for (int i = 0; i < 5; i++) begin
         cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
         exp_word = exp_q.pop_front();
         check($sformatf("stream tail%0d rd_data", i), int'(rd_data), int'(exp_word));
      end
      check_flags("stream end", 0);
      check("stream no errors", int'(overflow | underflow), 0);

      // Simultaneous write/read while full: read wins, write rejected.
      for (int i = 0; i < 16; i++) begin
         cycle(1'b0, 1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
         exp_q.push_back(8'(8'h30 + i));
      end
      cycle(1'b0, 1'b1, 8'hEE, 1'b1, 1'b0);
      exp_word = exp_q.pop_front();
      check("full wr+rd rd_valid", int'(rd_valid), 1);
      check("full wr+rd rd_data", int'(rd_data), int'(exp_word));
      check_flags("full wr+rd", 15);
      check("full wr+rd overflow", int'(overflow), 1);
      for (int i = 0; i < 15; i++) begin
         cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
         exp_word = exp_q.pop_front();
         check($sformatf("post-full%0d rd_data", i), int'(rd_data), int'(exp_word));
      end
      check_flags("post-full drained", 0);

      // Simultaneous write/read while empty: write wins, no bypass.
      cycle(1'b0, 1'b1, 8'h5A, 1'b1, 1'b1);
      check_flags("empty wr+rd", 1);
      check("empty wr+rd underflow", int'(underflow), 1);
      check("empty wr+rd rd_valid", int'(rd_valid), 0);
      cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      check("empty wr+rd readback valid", int'(rd_valid), 1);
      check("empty wr+rd readback data", int'(rd_data), 8'h5A);
      check_flags("empty wr+rd readback", 0);

      // Reset during traffic with 9 entries stored.
      cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      for (int i = 0; i < 9; i++) begin
         cycle(1'b0, 1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
      end
      check_flags("pre-reset", 9);
      cycle(1'b1, 1'b1, 8'h77, 1'b1, 1'b0);
      check_flags("mid reset", 0);
      check("mid reset rd_valid", int'(rd_valid), 0);
      check("mid reset rd_data", int'(rd_data), 0);
      check("mid reset overflow", int'(overflow), 0);
      cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      check("post-reset read rd_valid", int'(rd_valid), 0);
      check("post-reset read underflow", int'(underflow), 1);

      // clr_err coincident with a new overflow: set wins; then clr alone clears.
      cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      for (int i = 0; i < 16; i++) begin
         cycle(1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
      end
      check_flags("refill", 16);
      cycle(1'b0, 1'b1, 8'hBB, 1'b0, 1'b1);
      check("clr+overflow overflow", int'(overflow), 1);
      check("clr+overflow underflow", int'(underflow), 0);
      check_flags("clr+overflow", 16);
      cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      check("clr alone overflow", int'(overflow), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
